// File: rtl/matrix_alu_pkg.sv
// Shared constants, types and element helpers for the matrix ALU.
// Define MATRIX_ALU_SAT_EN for saturating ADD/SUB/SCALE/MULTI results instead of wrap-around.
package matrix_alu_pkg;

  localparam int unsigned ELEM_W = 16;
  localparam int unsigned DIM    = 4;
  localparam int unsigned MAT_W  = ELEM_W * DIM * DIM;
  localparam int unsigned ROW_W  = ELEM_W * DIM;
  // Wide enough for a full DIM-term dot product of ELEM_W operands.
  localparam int unsigned ACC_W  = 2 * ELEM_W + 8;
  localparam int unsigned IDX_W  = $clog2(DIM * DIM);

  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_SUB   = 8'h02;
  localparam logic [7:0] OP_SCALE = 8'h03;
  localparam logic [7:0] OP_TRANS = 8'h04;
  localparam logic [7:0] OP_MULTI = 8'h05;

  typedef enum logic [1:0] {StIdle, StWaitB, StBusy, StDone} state_e;

  typedef logic signed [ACC_W-1:0] acc_t;

`ifdef MATRIX_ALU_SAT_EN
  localparam acc_t ElemMax = acc_t'(2 ** (ELEM_W - 1) - 1);
  localparam acc_t ElemMin = -acc_t'(2 ** (ELEM_W - 1));
`endif

  function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned j);
    return (i * DIM + j) * ELEM_W;
  endfunction

  // Reduce a full-width result to one element: clamp or wrap depending on the build.
  function automatic logic [ELEM_W-1:0] fit_elem(input acc_t v);
`ifdef MATRIX_ALU_SAT_EN
    if (v > ElemMax) return ElemMax[ELEM_W-1:0];
    if (v < ElemMin) return ElemMin[ELEM_W-1:0];
`endif
    return v[ELEM_W-1:0];
  endfunction

endpackage

// File: rtl/matrix_dot_row.sv
// One element of a matrix product: dot product of a row of A with a column of B.
// Honours MATRIX_ALU_SAT_EN on the final sum only, via fit_elem.
module matrix_dot_row
  import matrix_alu_pkg::*;
(
  input  logic [ROW_W-1:0]  row,
  input  logic [ROW_W-1:0]  col,
  output logic [ELEM_W-1:0] dot
);

  acc_t prod [DIM];
  acc_t sum;

  always_comb begin
    for (int unsigned k = 0; k < DIM; k++) begin
      prod[k] = acc_t'($signed(row[k*ELEM_W +: ELEM_W])) *
                acc_t'($signed(col[k*ELEM_W +: ELEM_W]));
    end
  end

  always_comb begin
    sum = '0;
    for (int unsigned k = 0; k < DIM; k++) begin
      sum = sum + prod[k];
    end
  end

  assign dot = fit_elem(sum);

endmodule

// File: rtl/matrix_alu.sv
// ALU responder: captures operand matrices on load strobes and computes ADD/SUB/SCALE/TRANS/MULTI.
// MATRIX_ALU_SAT_EN (optional) switches arithmetic results from wrap-around to saturation.
module matrix_alu
  import matrix_alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             Load_Matrix1,
  input  logic             Load_Matrix2,
  input  logic [MAT_W-1:0] MemMatIn,
  input  logic [7:0]       Op_Code,
  input  logic [7:0]       SOURCE2,
  output logic [MAT_W-1:0] MemMatOut,
  output logic             FinishFlag
);

  localparam int unsigned RC_W = $clog2(DIM);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DIM * DIM - 1);

  logic [MAT_W-1:0]  a_q, b_q, res_q, res_d, ew_res;
  logic [7:0]        op_q, scalar_q;
  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              flag_q, flag_d;
  logic              load_b;
  logic [RC_W-1:0]   row_sel, col_sel;
  logic [ROW_W-1:0]  a_row, b_col;
  logic [ELEM_W-1:0] dot;

  // Load_Matrix1 takes priority; B is only accepted while waiting for it.
  assign load_b = Load_Matrix2 && !Load_Matrix1 && (state_q == StWaitB);

  assign row_sel = idx_q[IDX_W-1:RC_W];
  assign col_sel = idx_q[RC_W-1:0];
  assign a_row   = a_q[32'(row_sel) * ROW_W +: ROW_W];

  always_comb begin
    b_col = '0;
    for (int unsigned k = 0; k < DIM; k++) begin
      b_col[k*ELEM_W +: ELEM_W] = b_q[elem_lsb(k, 32'(col_sel)) +: ELEM_W];
    end
  end

  matrix_dot_row u_dot_row (
    .row (a_row),
    .col (b_col),
    .dot (dot)
  );

  always_comb begin
    acc_t ea, eb, es;
    ew_res = '0;
    ea = '0;
    eb = '0;
    es = acc_t'({1'b0, scalar_q});
    for (int unsigned i = 0; i < DIM; i++) begin
      for (int unsigned j = 0; j < DIM; j++) begin
        ea = acc_t'($signed(a_q[elem_lsb(i, j) +: ELEM_W]));
        eb = acc_t'($signed(b_q[elem_lsb(i, j) +: ELEM_W]));
        case (op_q)
          OP_ADD:   ew_res[elem_lsb(i, j) +: ELEM_W] = fit_elem(ea + eb);
          OP_SUB:   ew_res[elem_lsb(i, j) +: ELEM_W] = fit_elem(ea - eb);
          OP_SCALE: ew_res[elem_lsb(i, j) +: ELEM_W] = fit_elem(ea * es);
          OP_TRANS: ew_res[elem_lsb(i, j) +: ELEM_W] = a_q[elem_lsb(j, i) +: ELEM_W];
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    res_d   = res_q;
    flag_d  = flag_q;
    if (Load_Matrix1) begin
      flag_d  = 1'b0;
      idx_d   = '0;
      state_d = (Op_Code inside {OP_ADD, OP_SUB, OP_MULTI}) ? StWaitB : StBusy;
    end else begin
      unique case (state_q)
        StIdle, StDone: ;
        StWaitB: begin
          if (load_b) begin
            state_d = StBusy;
            idx_d   = '0;
          end
        end
        StBusy: begin
          if (op_q == OP_MULTI) begin
            res_d[32'(idx_q) * ELEM_W +: ELEM_W] = dot;
            idx_d = idx_q + 1'b1;
            if (idx_q == LastIdx) begin
              flag_d  = 1'b1;
              state_d = StDone;
            end
          end else begin
            res_d   = ew_res;
            flag_d  = 1'b1;
            state_d = StDone;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      res_q    <= '0;
      flag_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      scalar_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      flag_q  <= flag_d;
      if (Load_Matrix1) begin
        a_q      <= MemMatIn;
        op_q     <= Op_Code;
        scalar_q <= SOURCE2;
      end
      if (load_b) b_q <= MemMatIn;
    end
  end

  assign MemMatOut  = res_q;
  assign FinishFlag = flag_q;

endmodule

// File: tb/tb_matrix_alu.sv
// Self-checking bench for matrix_alu: directed corner cases plus randomized ops against a
// plain-arithmetic reference model.
module tb_matrix_alu;

  logic         clk = 1'b0;
  logic         reset;
  logic         l1, l2;
  logic [255:0] mat_in;
  logic [7:0]   op, src2;
  logic [255:0] mat_out;
  logic         flag;

  int checks   = 0;
  int failures = 0;

  matrix_alu dut (
    .clk          (clk),
    .reset        (reset),
    .Load_Matrix1 (l1),
    .Load_Matrix2 (l2),
    .MemMatIn     (mat_in),
    .Op_Code      (op),
    .SOURCE2      (src2),
    .MemMatOut    (mat_out),
    .FinishFlag   (flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] fill(input logic [15:0] v);
    logic [255:0] m;
    for (int e = 0; e < 16; e++) m[e*16 +: 16] = v;
    return m;
  endfunction

  function automatic logic [255:0] diag(input logic [15:0] d);
    logic [255:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[(i*4+i)*16 +: 16] = d;
    return m;
  endfunction

  // Element [i][j] = a*i + b*j.
  function automatic logic [255:0] lin(input int a, input int b);
    logic [255:0] m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) m[(i*4+j)*16 +: 16] = 16'(a*i + b*j);
    return m;
  endfunction

  function automatic logic [255:0] rand_mat();
    logic [255:0] m;
    for (int e = 0; e < 16; e++) begin
      if ($urandom_range(0, 3) == 0) m[e*16 +: 16] = 16'($urandom_range(0, 7));
      else m[e*16 +: 16] = 16'($urandom);
    end
    return m;
  endfunction

  function automatic logic [255:0] model(input logic [7:0] o, input logic [255:0] a,
                                         input logic [255:0] b, input logic [7:0] s);
    longint ma [4][4];
    longint mb [4][4];
    longint v;
    longint sc;
    logic [255:0] r;
    r  = '0;
    sc = longint'(s);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = longint'($signed(a[(i*4+j)*16 +: 16]));
        mb[i][j] = longint'($signed(b[(i*4+j)*16 +: 16]));
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        case (o)
          8'h01:   v = ma[i][j] + mb[i][j];
          8'h02:   v = ma[i][j] - mb[i][j];
          8'h03:   v = ma[i][j] * sc;
          8'h04:   v = ma[j][i];
          8'h05: begin
            v = 0;
            for (int k = 0; k < 4; k++) v += ma[i][k] * mb[k][j];
          end
          default: v = 0;
        endcase
`ifdef MATRIX_ALU_SAT_EN
        if (o != 8'h04) begin
          if (v > 32767) v = 32767;
          else if (v < -32768) v = -32768;
        end
`endif
        r[(i*4+j)*16 +: 16] = v[15:0];
      end
    return r;
  endfunction

  // Issues one operation and counts edges (including the last strobe's edge) until FinishFlag.
  task automatic run_op(input logic [7:0] o, input logic [255:0] a, input logic [255:0] b,
                        input logic [7:0] s, input bit use_b, output int lat);
    l1 = 1'b1; op = o; src2 = s; mat_in = a;
    tick();
    l1 = 1'b0;
    op = 8'($urandom); src2 = 8'($urandom);
    if (use_b) begin
      l2 = 1'b1; mat_in = b;
      tick();
      l2 = 1'b0;
    end
    mat_in = '0;
    lat = 1;
    while (!flag && lat < 40) begin
      tick();
      lat++;
    end
    if (!flag) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; l1 = 1'b0; l2 = 1'b0; mat_in = '1; op = 8'h05; src2 = 8'hFF;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (mat_out !== '0) begin
      failures++; $display("FAIL reset_out got=%h exp=0", mat_out);
    end
    checks++;
    if (flag !== 1'b0) begin
      failures++; $display("FAIL reset_flag got=%b exp=0", flag);
    end
  endtask

  task automatic test_add_basic();
    int lat;
    run_op(8'h01, fill(16'h0001), fill(16'h0002), 8'h00, 1'b1, lat);
    checks++;
    if (lat != 2) begin failures++; $display("FAIL add_latency got=%0d exp=2", lat); end
    checks++;
    if (mat_out !== fill(16'h0003)) begin
      failures++; $display("FAIL add_basic got=%h exp=%h", mat_out, fill(16'h0003));
    end
  endtask

  task automatic test_wrap();
    int lat;
    logic [255:0] exp;
`ifdef MATRIX_ALU_SAT_EN
    exp = fill(16'h7FFF);
`else
    exp = fill(16'h8000);
`endif
    run_op(8'h01, fill(16'h7FFF), fill(16'h0001), 8'h00, 1'b1, lat);
    checks++;
    if (mat_out !== exp) begin
      failures++; $display("FAIL add_overflow got=%h exp=%h", mat_out, exp);
    end
    run_op(8'h02, fill(16'h0000), fill(16'h0001), 8'h00, 1'b1, lat);
    checks++;
    if (mat_out !== fill(16'hFFFF)) begin
      failures++; $display("FAIL sub_neg got=%h exp=%h", mat_out, fill(16'hFFFF));
    end
  endtask

  task automatic test_scale_trans();
    int lat;
    run_op(8'h03, diag(16'h0001), '0, 8'd42, 1'b0, lat);
    checks++;
    if (lat != 2) begin failures++; $display("FAIL scale_latency got=%0d exp=2", lat); end
    checks++;
    if (mat_out !== diag(16'h002A)) begin
      failures++; $display("FAIL scale_ident got=%h exp=%h", mat_out, diag(16'h002A));
    end
    run_op(8'h04, lin(4, 1), '0, 8'h00, 1'b0, lat);
    checks++;
    if (mat_out !== lin(1, 4)) begin
      failures++; $display("FAIL trans_ramp got=%h exp=%h", mat_out, lin(1, 4));
    end
  endtask

  task automatic test_multi();
    int lat;
    run_op(8'h05, diag(16'h0002), lin(4, 1), 8'h00, 1'b1, lat);
    checks++;
    if (lat != 1 + 16) begin failures++; $display("FAIL multi_latency got=%0d exp=17", lat); end
    checks++;
    if (mat_out !== lin(8, 2)) begin
      failures++; $display("FAIL multi_diag got=%h exp=%h", mat_out, lin(8, 2));
    end
  endtask

  task automatic test_hold();
    logic [255:0] held;
    held = mat_out;
    l2 = 1'b1; mat_in = '1;
    repeat (3) tick();
    l2 = 1'b0;
    repeat (3) tick();
    checks++;
    if (flag !== 1'b1 || mat_out !== held) begin
      failures++; $display("FAIL done_hold got=%b/%h exp=1/%h", flag, mat_out, held);
    end
  endtask

  task automatic test_random();
    logic [7:0] ops [8];
    logic [7:0] o, s;
    logic [255:0] a, b, exp;
    int lat, exp_lat;
    ops = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'hFF, 8'h00};
    for (int n = 0; n < 20; n++) begin
      o = ops[$urandom_range(0, 7)];
      if (o == 8'h00 && $urandom_range(0, 1) == 1) o = 8'($urandom_range(6, 254));
      s = 8'($urandom);
      a = rand_mat();
      b = rand_mat();
      exp = model(o, a, b, s);
      exp_lat = (o == 8'h05) ? 17 : 2;
      run_op(o, a, b, s, (o == 8'h01 || o == 8'h02 || o == 8'h05), lat);
      checks++;
      if (lat != exp_lat) begin
        failures++; $display("FAIL rand_latency op=%h got=%0d exp=%0d", o, lat, exp_lat);
      end
      checks++;
      if (mat_out !== exp) begin
        failures++; $display("FAIL rand_result op=%h got=%h exp=%h", o, mat_out, exp);
      end
    end
  endtask

  task automatic test_reset_mid_multi();
    l1 = 1'b1; op = 8'h05; mat_in = lin(4, 1);
    tick();
    l1 = 1'b0; l2 = 1'b1; mat_in = lin(1, 3);
    tick();
    l2 = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (mat_out !== '0 || flag !== 1'b0) begin
      failures++; $display("FAIL reset_mid_multi got=%b/%h exp=0/0", flag, mat_out);
    end
    l2 = 1'b1; mat_in = lin(2, 2);
    tick();
    l2 = 1'b0;
    repeat (20) tick();
    checks++;
    if (mat_out !== '0 || flag !== 1'b0) begin
      failures++; $display("FAIL l2_after_reset got=%b/%h exp=0/0", flag, mat_out);
    end
  endtask

  task automatic test_abort();
    logic [255:0] a2, exp;
    a2  = rand_mat();
    exp = model(8'h04, a2, '0, 8'h00);
    l1 = 1'b1; op = 8'h05; mat_in = lin(4, 1);
    tick();
    l1 = 1'b0; l2 = 1'b1; mat_in = lin(4, 1);
    tick();
    l2 = 1'b0;
    repeat (5) tick();
    l1 = 1'b1; op = 8'h04; mat_in = a2;
    tick();
    l1 = 1'b0;
    checks++;
    if (flag !== 1'b0) begin failures++; $display("FAIL abort_early_flag got=%b exp=0", flag); end
    tick();
    checks++;
    if (flag !== 1'b1 || mat_out !== exp) begin
      failures++; $display("FAIL abort_trans got=%b/%h exp=1/%h", flag, mat_out, exp);
    end
    repeat (20) tick();
    checks++;
    if (flag !== 1'b1 || mat_out !== exp) begin
      failures++; $display("FAIL abort_no_resume got=%b/%h exp=1/%h", flag, mat_out, exp);
    end
  endtask

  task automatic test_collision();
    logic [255:0] a, b, exp;
    a = rand_mat();
    b = rand_mat();
    exp = model(8'h01, a, b, 8'h00);
    l1 = 1'b1; l2 = 1'b1; op = 8'h01; mat_in = a;
    tick();
    l1 = 1'b0; l2 = 1'b0; mat_in = '0;
    repeat (4) tick();
    checks++;
    if (flag !== 1'b0) begin failures++; $display("FAIL collision_l2_dropped got=%b exp=0", flag); end
    l2 = 1'b1; mat_in = b;
    tick();
    l2 = 1'b0;
    tick();
    checks++;
    if (flag !== 1'b1 || mat_out !== exp) begin
      failures++; $display("FAIL collision_add got=%b/%h exp=1/%h", flag, mat_out, exp);
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_hold();
    test_wrap();
    test_scale_trans();
    test_multi();
    test_random();
    test_reset_mid_multi();
    test_abort();
    test_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
